tape_beat_sequencer: RTL

//   Tick consumer for the paper-tape player: walks tape rows in a ROM, one row per note.

---
 rtl/tape_beat_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tape_beat_sequencer.sv
// rtl/tape_beat_sequencer.sv - paper-tape row sequencer: fetches ROM rows, holds each note for d+1 beat ticks
module tape_beat_sequencer #(
  parameter int ADDR_W = 6,
  parameter int NOTE_W = 5,
  parameter int DUR_W  = 3,
  parameter int DATA_W = 1 + NOTE_W + DUR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              tick,
  output logic              tick_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note,
  output logic              note_on,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    PLAY   = 3'd3,
    PAUSE  = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = {ADDR_W{1'b1}};

  state_t             state;
  logic [DUR_W-1:0]   dur_cnt;

  logic               row_end;
  logic [NOTE_W-1:0]  row_note;
  logic [DUR_W-1:0]   row_dur;

  assign row_end  = rom_data[DATA_W-1];
  assign row_note = rom_data[DUR_W +: NOTE_W];
  assign row_dur  = rom_data[DUR_W-1:0];

  assign busy    = (state != IDLE);
  assign tick_en = (state == PLAY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      note     <= '0;
      note_on  <= 1'b0;
      done     <= 1'b0;
      dur_cnt  <= '0;
    end else if (stop) begin
      // Abort rewinds silently: no done pulse, next play starts at row 0.
      state    <= IDLE;
      rom_addr <= '0;
      note     <= '0;
      note_on  <= 1'b0;
      done     <= 1'b0;
      dur_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (play) state <= FETCH;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          if (row_end) begin
            state   <= FINISH;
            done    <= 1'b1;
            note    <= '0;
            note_on <= 1'b0;
          end else begin
            note    <= row_note;
            dur_cnt <= row_dur;
            note_on <= (row_note != '0);
            state   <= PLAY;
          end
        end
        PLAY: begin
          // Pause wins over a coincident tick, so that tick is never counted.
          if (!play) begin
            state   <= PAUSE;
            note_on <= 1'b0;
          end else if (tick) begin
            if (dur_cnt != '0) begin
              dur_cnt <= dur_cnt - 1'b1;
            end else if (rom_addr == LAST_ROW) begin
              state   <= FINISH;
              done    <= 1'b1;
              note    <= '0;
              note_on <= 1'b0;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        PAUSE: begin
          if (play) begin
            state   <= PLAY;
            note_on <= (note != '0);
          end
        end
        FINISH: begin
          rom_addr <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
